// File: rtl/data_sram_responder.sv
// Data SRAM responder for the EXE/MEM data port: byte-masked writes, fixed-latency reads,
// a sticky out-of-window error flag and counters for in-window reads and writes.
module data_sram_responder #(
    parameter int          ADDR_W    = 16,
    parameter int          READ_LAT  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        access_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $fatal(1, "data_sram_responder: READ_LAT=%0d outside 1..4", READ_LAT);
    end

    logic [31:0]       mem [DEPTH];
    logic              hit;
    logic [ADDR_W-1:0] idx;
    logic              rd_req;
    logic              wr_req;
    logic              unused_addr_lsb;

    assign hit    = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign idx    = data_sram_addr[ADDR_W+1:2];
    assign rd_req = resetn && data_sram_en && (data_sram_we == 4'b0000);
    assign wr_req = resetn && data_sram_en && (data_sram_we != 4'b0000) && hit;
    assign unused_addr_lsb = ^data_sram_addr[1:0];

    // Array: byte-lane writes, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_req) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 samples the array at the request edge, last stage drives the port
    logic [READ_LAT-1:0] vld_p;
    logic [31:0]         dat_p [READ_LAT];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_req;
            for (int k = 1; k < READ_LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
    end

    // Stages only load on a valid entry, so the last stage holds the previous response
    always_ff @(posedge clk) begin
        for (int k = READ_LAT - 1; k >= 1; k--) begin
            if (vld_p[k-1]) begin
                dat_p[k] <= dat_p[k-1];
            end
        end
        if (rd_req) begin
            dat_p[0] <= hit ? mem[idx] : 32'h0;
        end
        if (!resetn) begin
            dat_p[READ_LAT-1] <= 32'h0;
        end
    end

    assign data_sram_rvalid = vld_p[READ_LAT-1];
    assign data_sram_rdata  = dat_p[READ_LAT-1];

    // Status and statistics
    always_ff @(posedge clk) begin
        if (!resetn) begin
            access_err <= 1'b0;
            rd_cnt     <= 32'h0;
            wr_cnt     <= 32'h0;
        end else if (data_sram_en) begin
            if (!hit) begin
                access_err <= 1'b1;
            end
            if (rd_req && hit) begin
                rd_cnt <= rd_cnt + 32'h1;
            end
            if (wr_req) begin
                wr_cnt <= wr_cnt + 32'h1;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: a word-array model predicts every response,
// counter and error flag; a monitor compares them one cycle-edge at a time.
module tb_data_sram_responder;

    localparam int          LAT  = 3;
    localparam logic [31:0] BASE = 32'h1c000000;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    data_sram_responder #(
        .ADDR_W   (16),
        .READ_LAT (LAT),
        .BASE_ADDR(BASE)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .data_sram_rvalid(rvalid),
        .access_err      (err),
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd    = 32'h0;
    logic [31:0] exp_wr    = 32'h0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err   = 1'b0;
    int          edge_n    = 0;
    int          compared  = 0;
    int          mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h, expected %08h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor: runs just after every rising edge, once the DUT has settled
    initial begin
        rsp_t r;
        logic exp_v;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            check("access_err", {31'h0, err}, {31'h0, exp_err});
            check("rd_cnt", rd_cnt, exp_rd);
            check("wr_cnt", wr_cnt, exp_wr);
            exp_v = (q.size() > 0) && (q[0].due <= edge_n);
            check("rvalid", {31'h0, rvalid}, {31'h0, exp_v});
            if (exp_v) begin
                r = q.pop_front();
                if (rvalid) begin
                    check("rdata", rdata, r.data);
                    exp_rdata = r.data;
                end
            end else if (!rvalid) begin
                check("rdata_hold", rdata, exp_rdata);
            end
        end
    end

    // Drive one cycle of inputs and predict its effect; returns on the following falling edge
    task automatic issue(input logic rst_n, input logic en_i, input logic [3:0] we_i,
                         input logic [31:0] addr_i, input logic [31:0] wd_i);
        logic        hit_m;
        int          idx_m;
        logic [31:0] w;
        rsp_t        r;
        resetn = rst_n;
        en     = en_i;
        we     = we_i;
        addr   = addr_i;
        wdata  = wd_i;
        hit_m  = (addr_i >> 18) == (BASE >> 18);
        idx_m  = int'((addr_i - BASE) >> 2);
        if (!rst_n) begin
            q.delete();
            exp_rd    = 32'h0;
            exp_wr    = 32'h0;
            exp_err   = 1'b0;
            exp_rdata = 32'h0;
        end else if (en_i) begin
            if (!hit_m) exp_err = 1'b1;
            if (we_i == 4'b0000) begin
                r.due  = edge_n + LAT;
                r.data = hit_m ? ref_mem[idx_m] : 32'h0;
                q.push_back(r);
                if (hit_m) exp_rd = exp_rd + 32'h1;
            end else if (hit_m) begin
                w = ref_mem.exists(idx_m) ? ref_mem[idx_m] : 32'h0;
                for (int i = 0; i < 4; i++) begin
                    if (we_i[i]) w[8*i +: 8] = wd_i[8*i +: 8];
                end
                ref_mem[idx_m] = w;
                exp_wr = exp_wr + 32'h1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  w_en;
        resetn = 1'b0;
        en     = 1'b0;
        we     = 4'h0;
        addr   = 32'h0;
        wdata  = 32'h0;
        @(negedge clk);
        issue(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        issue(1'b0, 1'b1, 4'hf, BASE, 32'h12345678);

        for (int i = 0; i < 16; i++) issue(1'b1, 1'b1, 4'hf, BASE + 32'(4 * i), $urandom);

        // Full write then immediate read-back
        issue(1'b1, 1'b1, 4'hf, BASE + 32'h10, 32'hdeadbeef);
        issue(1'b1, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
        idle(LAT);

        // Byte-masked merge: 11223344 with lanes 0,2 of aabbccdd -> 11bb33dd
        issue(1'b1, 1'b1, 4'hf, BASE + 32'h20, 32'h11223344);
        issue(1'b1, 1'b1, 4'b0101, BASE + 32'h20, 32'haabbccdd);
        issue(1'b1, 1'b1, 4'h0, BASE + 32'h20, 32'h0);
        idle(LAT);

        for (int i = 0; i < 4; i++) issue(1'b1, 1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
        idle(LAT + 1);

        // Out-of-window read and write; the aliased in-window word must be untouched
        issue(1'b1, 1'b1, 4'h0, 32'h00000000, 32'h0);
        issue(1'b1, 1'b1, 4'hf, 32'h00000010, 32'hcafef00d);
        issue(1'b1, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
        idle(LAT + 2);

        // Reset while a read is in flight, then confirm the array kept its data
        issue(1'b1, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
        issue(1'b0, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
        idle(LAT + 2);
        issue(1'b1, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
        idle(LAT + 1);

        // Write counter wrap
        force dut.wr_cnt = 32'hffffffff;
        exp_wr = 32'hffffffff;
        #1;
        release dut.wr_cnt;
        issue(1'b1, 1'b1, 4'hf, BASE + 32'h30, 32'h0badf00d);
        idle(3);

        for (int n = 0; n < 400; n++) begin
            a = BASE + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) a = $urandom & 32'h0ffffffc;
            w_en = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            issue(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), w_en, a, $urandom);
        end
        idle(LAT + 2);

        check("drain", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
